// File: rtl/debug_uart_rx.sv
// 8N1 UART receiver with a first-word-fall-through byte FIFO on a valid/ready output.
// Framing errors and FIFO overruns are reported as single-cycle pulses.
module debug_uart_rx #(
    parameter int unsigned CLKS_PER_BIT    = 1085,
    parameter int unsigned FIFO_DEPTH_LOG2 = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] dout,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned MID   = CLKS_PER_BIT / 2;
    localparam int unsigned CW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int unsigned PW    = FIFO_DEPTH_LOG2;

    localparam logic [CW-1:0] CNT_MID_M1 = CW'(MID - 1);
    localparam logic [CW-1:0] CNT_MID    = CW'(MID);
    localparam logic [CW-1:0] CNT_DECIDE = CW'(MID + 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [PW:0]   CNT_FULL   = (PW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [1:0]    smp_q, smp_d;
    logic [7:0]    shift_q, shift_d;
    logic          sync1_q, rxs_q, prev_q;
    logic          busy_q;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;

    logic fall;
    logic vote;
    logic push;
    logic pop;
    logic full;
    logic push_ok;

    // rxd synchronizer plus previous-sample flop; all reset high so reset never looks like a start edge
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rxd;
            rxs_q   <= sync1_q;
            prev_q  <= rxs_q;
        end
    end

    assign fall = prev_q & ~rxs_q;
    assign vote = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs_q) | (smp_q[1] & rxs_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            smp_q       <= '1;
            shift_q     <= '0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            smp_q       <= smp_d;
            shift_q     <= shift_d;
            busy_q      <= (state_d != S_IDLE);
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CW'(1);
        bit_idx_d   = bit_idx_q;
        smp_d       = smp_q;
        shift_d     = shift_q;
        push        = 1'b0;
        frame_err_d = 1'b0;

        if (state_q != S_IDLE) begin
            if (cnt_q == CNT_MID_M1) smp_d[0] = rxs_q;
            if (cnt_q == CNT_MID)    smp_d[1] = rxs_q;
        end

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (fall) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == CNT_DECIDE && vote) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = S_DATA;
                    cnt_d     = '0;
                    bit_idx_d = '0;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_DECIDE) shift_d[bit_idx_q] = vote;
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (bit_idx_q == 3'd7) state_d = S_STOP;
                    else                   bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            S_STOP: begin
                // Leave at the stop-bit decision so a following start edge is never missed
                if (cnt_q == CNT_DECIDE) begin
                    if (vote) push = 1'b1;
                    else      frame_err_d = 1'b1;
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign full      = (count_q == CNT_FULL);
    assign pop       = (count_q != '0) & dout_ready;
    assign push_ok   = push & (~full | pop);
    assign overrun_d = push & full & ~pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + (PW + 1)'(1);
            2'b01:   count_d = count_q - (PW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) mem_q[wr_ptr_q] <= shift_q;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout       = mem_q[rd_ptr_q];
    assign dout_valid = (count_q != '0);
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_debug_uart_rx.sv
// Directed bench for debug_uart_rx: a frame-level scoreboard predicts FIFO contents,
// error pulses and busy windows, checked every cycle, plus literal per-scenario checks.
module tb_debug_uart_rx;

    localparam int CPB   = 16;
    localparam int MID   = CPB / 2;
    localparam int DEPTH = 4;
    // Edges from the first low rxd sample to the stop-bit decision edge:
    // 2 sync stages, 9 full bits, then mid-bit decision (MID+1) plus the registering edge.
    localparam int LAT   = 2 + 9 * CPB + MID + 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic       dout_ready = 1'b0;
    logic [7:0] dout;
    logic       dout_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    debug_uart_rx #(
        .CLKS_PER_BIT   (CPB),
        .FIFO_DEPTH_LOG2(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] mq[$];
    int         ev_kind[int];
    logic [7:0] ev_byte[int];
    int         b_start = 0;
    int         b_end   = 0;
    logic       exp_ferr = 1'b0;
    logic       exp_ovr  = 1'b0;

    logic [7:0] pop_log[$];
    int n_ferr = 0, n_ovr = 0, n_valid = 0, busy_seen = 0;
    int first_valid_edge = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Scoreboard: applies reset, pops and scheduled frame outcomes at each edge
    always @(posedge clk) begin
        logic pop_m, push_m, full_m;
        cyc = cyc + 1;
        exp_ferr = 1'b0;
        exp_ovr  = 1'b0;
        if (rst) begin
            mq.delete();
            ev_kind.delete();
            ev_byte.delete();
            b_end = 0;
        end else begin
            pop_m  = (mq.size() > 0) && dout_ready;
            full_m = (mq.size() == DEPTH);
            push_m = 1'b0;
            if (ev_kind.exists(cyc)) begin
                if (ev_kind[cyc] == 1) push_m = 1'b1;
                else                   exp_ferr = 1'b1;
            end
            if (push_m && full_m && !pop_m) exp_ovr = 1'b1;
            if (pop_m) void'(mq.pop_front());
            if (push_m && !exp_ovr) mq.push_back(ev_byte[cyc]);
            if (ev_kind.exists(cyc)) begin
                ev_kind.delete(cyc);
                ev_byte.delete(cyc);
            end
        end
    end

    always @(negedge clk) begin
        check("dout_valid", {31'd0, dout_valid}, {31'd0, mq.size() > 0});
        if (mq.size() > 0) check("dout", {24'd0, dout}, {24'd0, mq[0]});
        check("frame_err", {31'd0, frame_err}, {31'd0, exp_ferr});
        check("overrun", {31'd0, overrun}, {31'd0, exp_ovr});
        check("busy", {31'd0, busy}, {31'd0, (cyc >= b_start) && (cyc < b_end)});
        if (dout_valid && dout_ready) pop_log.push_back(dout);
        if (frame_err) n_ferr++;
        if (overrun) n_ovr++;
        if (busy) busy_seen++;
        if (dout_valid) begin
            n_valid++;
            if (first_valid_edge < 0) first_valid_edge = cyc;
        end
    end

    task automatic bit_out(input logic v);
        rxd = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        rxd = 1'b1;
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        int n;
        n = cyc;
        ev_kind[n + 1 + LAT] = stop ? 1 : 2;
        ev_byte[n + 1 + LAT] = b;
        b_start = n + 3;
        b_end   = n + 1 + LAT;
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(b[i]);
        bit_out(stop);
    endtask

    task automatic clear_mon();
        pop_log.delete();
        n_ferr = 0; n_ovr = 0; n_valid = 0; busy_seen = 0;
        first_valid_edge = -1;
    endtask

    initial begin
        int n, p;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", {24'd0, dout}, 32'h0);
        check("rst_valid", {31'd0, dout_valid}, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'h0);
        check("rst_errs", {30'd0, frame_err, overrun}, 32'h0);
        rst = 1'b0;
        idle(20);

        // 0x55, consumer always ready
        dout_ready = 1'b1;
        clear_mon();
        n = cyc;
        send_frame(8'h55, 1'b1);
        idle(20);
        check("t1_valid_cycles", n_valid, 1);
        check("t1_pops", pop_log.size(), 1);
        if (pop_log.size() > 0) check("t1_byte", {24'd0, pop_log[0]}, 32'h55);
        check("t1_latency", first_valid_edge - n, 157);
        check("t1_errs", n_ferr + n_ovr, 0);

        // 3-cycle glitch rejected in START
        clear_mon();
        n = cyc;
        b_start = n + 3;
        b_end   = n + MID + 5;
        rxd = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        idle(40);
        check("t2_busy_seen", {31'd0, busy_seen > 0}, 32'h1);
        check("t2_busy_len", busy_seen, MID + 2);
        check("t2_no_byte", n_valid + n_ferr, 0);

        // framing error, break, then clean frame
        clear_mon();
        send_frame(8'hA5, 1'b0);
        rxd = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        idle(32);
        send_frame(8'h3C, 1'b1);
        idle(20);
        check("t3_ferr", n_ferr, 1);
        check("t3_pops", pop_log.size(), 1);
        if (pop_log.size() > 0) check("t3_byte", {24'd0, pop_log[0]}, 32'h3C);

        // overrun on 5th back-to-back byte
        dout_ready = 1'b0;
        clear_mon();
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        idle(20);
        check("t4_ovr", n_ovr, 1);
        dout_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("t4_pops", pop_log.size(), 4);
        for (int i = 0; i < 4 && i < pop_log.size(); i++)
            check("t4_order", {24'd0, pop_log[i]}, i + 1);
        check("t4_empty", {31'd0, dout_valid}, 32'h0);

        // push and pop on the same edge while full
        dout_ready = 1'b0;
        clear_mon();
        for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1);
        n = cyc;
        p = n + 1 + LAT;
        fork
            send_frame(8'h14, 1'b1);
            begin
                while (cyc < p - 1) begin
                    @(posedge clk);
                    #1;
                end
                dout_ready = 1'b1;
                @(posedge clk);
                #1;
                dout_ready = 1'b0;
            end
        join
        idle(20);
        check("t5_no_ovr", n_ovr, 0);
        dout_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("t5_pops", pop_log.size(), 5);
        for (int i = 0; i < 5 && i < pop_log.size(); i++)
            check("t5_order", {24'd0, pop_log[i]}, 32'h10 + i);

        // reset during DATA bit 3 with two bytes queued
        dout_ready = 1'b0;
        send_frame(8'hA1, 1'b1);
        send_frame(8'hA2, 1'b1);
        n = cyc;
        fork
            send_frame(8'hF8, 1'b1);
            begin
                while (cyc < n + 4 * CPB + 8) begin
                    @(posedge clk);
                    #1;
                end
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                check("t6_busy", {31'd0, busy}, 32'h0);
                check("t6_valid", {31'd0, dout_valid}, 32'h0);
                check("t6_dout", {24'd0, dout}, 32'h0);
            end
        join
        idle(40);
        dout_ready = 1'b1;
        clear_mon();
        send_frame(8'hC3, 1'b1);
        idle(20);
        check("t6_pops", pop_log.size(), 1);
        if (pop_log.size() > 0) check("t6_byte", {24'd0, pop_log[0]}, 32'hC3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
